ripple_cnt_monitor: RTL
=======================

// Module: ripple_cnt_monitor
// PURPOSE
//  Consumer stage for the 4-bit ripple (asynchronous) down-counter. Samples its
//  asynchronous q bus into the system clock domain and filters ripple transients.
//  Produces terminal-count and wrap events, a saturating wrap tally and an
//  armed threshold alarm driven by an FSM.
// PARAMETERS
//  WIDTH   4  width of the counter bus being monitored
//  WCNT_W  8  width of the saturating wrap counter
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous reset, active-high
//  cnt_in      in   WIDTH    ripple counter q bus (asynchronous to clk)
//  threshold   in   WIDTH    alarm compare value (synchronous, quasi-static)
//  arm         in   1        single-cycle request to arm the alarm
//  ack         in   1        single-cycle alarm acknowledge / disarm
//  clr_wraps   in   1        clears wrap_count (and step_err)
//  cnt_stable  out  WIDTH    filtered, synchronised counter value
//  cnt_valid   out  1        cnt_stable holds an accepted sample
//  tc_pulse    out  1        1-cycle pulse: accepted value became 0
//  wrap_pulse  out  1        1-cycle pulse: accepted value went 0 -> all-ones
//  wrap_count  out  WCNT_W   number of wraps seen, saturating
//  alarm       out  1        high while FSM is in ALARM
//  step_err    out  1        sticky illegal-step flag (see CONFIGURATION)
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-high (rst). All flops reset to 0:
//    cnt_stable=0, cnt_valid=0, tc_pulse=0, wrap_pulse=0, wrap_count=0,
//    alarm=0, step_err=0, FSM=IDLE. rst asserted mid-operation aborts everything.
//  - Sync/filter: s1<=cnt_in; s2<=s1; s3<=s2 (all bits). When s2==s3, cnt_stable<=s2
//    and cnt_valid<=1. While s2!=s3, cnt_stable holds.
//    Latency: cnt_in held constant updates cnt_stable on the 4th clk rising edge.
//  - Accept event = cycle in which cnt_stable loads a value different from its previous value
//    while cnt_valid was already 1. The first accepted sample after reset sets cnt_valid
//    and raises no events.
//  - tc_pulse: registered. High for exactly one cycle on the edge after an accept
//    event whose new value is 0.
//  - wrap_pulse: registered. High for one cycle after an accept event with old==0
//    and new=={WIDTH{1'b1}}.
//  - wrap_count: increments on each wrap_pulse and saturates at all-ones.
//    clr_wraps clears it to 0. If clr_wraps and an increment coincide, clear wins (result 0).
//  - FSM states IDLE, ARMED, ALARM. alarm = (state==ALARM).
//    IDLE : arm -> ARMED; otherwise stay.
//    ARMED: ack -> IDLE (ack has priority). Else if cnt_valid && cnt_stable==threshold
//           -> ALARM. Level compare, so a value already matching alarms 1 cycle after arming.
//    ALARM: ack -> IDLE; arm is ignored; arm+ack in the same cycle -> IDLE.
//  - Pulses are never merged or stretched. Back-to-back accept events each produce their own pulse.
// CONFIGURATION
//  STEP_ERR_EN defined: on an accept event, if new != (old-1) mod 2^WIDTH, step_err<=1
//    (sticky; this detects a missed count or a ripple rate too fast for clk).
//    The 0->all-ones wrap is a legal step. clr_wraps clears step_err.
//    If clr_wraps coincides with a new error, set wins.
//  STEP_ERR_EN undefined: the step_err port remains and is tied to 0. No checker logic is built.
// TESTING
//  1. rst=1 mid-count -> every output reads 0 immediately (asynchronous). After release,
//     cnt_valid=0 until the first sample is accepted.
//  2. Hold cnt_in=4'h9 -> cnt_stable=9 on the 4th edge. Force a 1-cycle glitch of 4'h7 ->
//     cnt_stable never shows 7.
//  3. Step cnt_in 2,1,0,F,E, each held 6 cycles -> tc_pulse once after 0; wrap_pulse once
//     after F; wrap_count=1.
//  4. Wrap 300 times with WCNT_W=8 -> wrap_count=255. clr_wraps together with a wrap ->
//     wrap_count=0.
//  5. threshold=5, arm, count down past 5 -> alarm rises 1 cycle after cnt_stable=5.
//     ack -> IDLE. arm+ack in ARMED -> IDLE.
//  6. STEP_ERR_EN on: step 8->6 -> step_err=1 and stays set. 0->F gives no error.
//     Macro off -> step_err stays 0.

Source files
------------

// File: rtl/ripple_cnt_monitor.sv
// ripple_cnt_monitor: brings an asynchronous ripple down-counter bus into the clk domain,
// filters ripple transients and reports terminal-count/wrap events, a wrap tally and an alarm.
// Optional feature macro: STEP_ERR_EN builds the sticky illegal-step checker.
module ripple_cnt_monitor #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned WCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic [WIDTH-1:0]  threshold,
   input  logic              arm,
   input  logic              ack,
   input  logic              clr_wraps,
   output logic [WIDTH-1:0]  cnt_stable,
   output logic              cnt_valid,
   output logic              tc_pulse,
   output logic              wrap_pulse,
   output logic [WCNT_W-1:0] wrap_count,
   output logic              alarm,
   output logic              step_err
);

   localparam logic [WIDTH-1:0]  CNT_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]  CNT_ZERO = '0;
   localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
   localparam logic [WCNT_W-1:0] WCNT_MAX = {WCNT_W{1'b1}};
   localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      ALARM = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] s3;
   logic             load;
   logic             accept;

   // Two-flop synchroniser plus a third stage used only for the stability compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= cnt_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign load   = (s2 == s3);
   assign accept = load && cnt_valid && (s2 != cnt_stable);

   // Filtered value and the per-accept event pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_stable <= '0;
         cnt_valid  <= 1'b0;
         tc_pulse   <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         tc_pulse   <= accept && (s2 == CNT_ZERO);
         wrap_pulse <= accept && (cnt_stable == CNT_ZERO) && (s2 == CNT_ONES);
         if (load) begin
            cnt_stable <= s2;
            cnt_valid  <= 1'b1;
         end
      end
   end

   // Saturating wrap tally; clear beats a coincident increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_count <= '0;
      end else if (clr_wraps) begin
         wrap_count <= '0;
      end else if (wrap_pulse && (wrap_count != WCNT_MAX)) begin
         wrap_count <= wrap_count + WCNT_ONE;
      end
   end

`ifdef STEP_ERR_EN
   logic step_bad;

   // A legal accept is exactly one count down (modulo 2^WIDTH, so 0 -> all-ones is fine).
   assign step_bad = accept && (s2 != WIDTH'(cnt_stable - CNT_ONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_err <= 1'b0;
      end else if (step_bad) begin
         step_err <= 1'b1;
      end else if (clr_wraps) begin
         step_err <= 1'b0;
      end
   end
`else
   assign step_err = 1'b0;
`endif

   // Alarm FSM state register; alarm is registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         alarm <= 1'b0;
      end else begin
         state <= state_nxt;
         alarm <= (state_nxt == ALARM);
      end
   end

   // Next-state logic: ack always wins, arm is ignored outside IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (arm) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (ack) begin
               state_nxt = IDLE;
            end else if (cnt_valid && (cnt_stable == threshold)) begin
               state_nxt = ALARM;
            end
         end
         ALARM: begin
            if (ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
